// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short/long/double-click/repeat pulses.
// Optional auto-repeat in HOLD is enabled by defining KEY_REPEAT_EN.
module key_event_decoder #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned LONG_TICKS   = 50_000_000,
  parameter int unsigned DBL_TICKS    = 15_000_000,
  parameter int unsigned REPEAT_TICKS = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_MAX  = CNT_W'(DBL_TICKS - 1);

  if ((64'(LONG_TICKS) > (64'(1) << CNT_W)) ||
      (64'(DBL_TICKS) > (64'(1) << CNT_W)) ||
      (64'(REPEAT_TICKS) > (64'(1) << CNT_W))) begin : g_cnt_w_check
    $error("CNT_W too narrow for tick parameters");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press, rel;
  logic             sp_nxt, lp_nxt, dc_nxt;

  assign press = key_flag & ~key_state;
  assign rel   = key_flag & key_state;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_TICKS - 1);
  logic rp_nxt;
`endif

  // Key events are tested before timeouts so a coincident flag wins.
  always_comb begin
    state_nxt = state;
    sp_nxt    = 1'b0;
    lp_nxt    = 1'b0;
    dc_nxt    = 1'b0;
`ifdef KEY_REPEAT_EN
    rp_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_MAX) begin
          lp_nxt    = 1'b1;
          state_nxt = HOLD;
        end
      end
      WAIT2: begin
        if (press) begin
          state_nxt = PRESS2;
        end else if (cnt == DBL_MAX) begin
          sp_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESS2: begin
        if (rel) begin
          dc_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LONG_MAX) begin
          lp_nxt    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rel) begin
          state_nxt = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt == REP_MAX) begin
          rp_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (state == HOLD) begin
`ifdef KEY_REPEAT_EN
      if (rp_nxt) cnt_nxt = '0;
`else
      if (&cnt) cnt_nxt = cnt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
`ifdef KEY_REPEAT_EN
      key_repeat   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= sp_nxt;
      long_press   <= lp_nxt;
      double_click <= dc_nxt;
      busy         <= (state_nxt != IDLE);
`ifdef KEY_REPEAT_EN
      key_repeat   <= rp_nxt;
`endif
    end
  end

`ifndef KEY_REPEAT_EN
  assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random
// edge sequences checked against an edge-interval event model.
module tb_key_event_decoder;

  localparam int LT = 20;
  localparam int DT = 10;
  localparam int RT = 5;
  localparam int NC = 8192;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, key_flag, key_state;
  logic short_press, long_press, double_click, key_repeat, busy;

  int tests = 0;
  int fails = 0;
  int t_now = 0;

  // bit 0 short, 1 long, 2 double, 3 repeat, 4 busy
  logic [4:0] obs  [NC];
  logic [4:0] expv [NC];

  key_event_decoder #(
    .CNT_W(8),
    .LONG_TICKS(LT),
    .DBL_TICKS(DT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_flag(key_flag),
    .key_state(key_state),
    .short_press(short_press),
    .long_press(long_press),
    .double_click(double_click),
    .key_repeat(key_repeat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {busy, key_repeat, double_click, long_press, short_press};
  endfunction

  // Drive cycle t_now, then record what is visible in cycle t_now+1.
  task automatic step(input logic f, input logic s);
    key_flag  = f;
    key_state = s;
    @(posedge clk);
    #1;
    t_now++;
    if (t_now < NC) obs[t_now] = outs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  function automatic int nbits(input int b, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (obs[c][b]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b1);
    tests++;
    if (obs[t_now] !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b expected 00000", obs[t_now]);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_short();
    int t = t_now;
    step(1'b0 == 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1);
    idle(25);
    tests++;
    if (nbits(0, t + 1, t + 31) !== 1 || obs[t + 16][0] !== 1'b1) begin
      fails++;
      $display("FAIL short_pulse: got n=%0d at16=%b expected 1 at T+16",
               nbits(0, t + 1, t + 31), obs[t + 16][0]);
    end
    tests++;
    if (nbits(1, t + 1, t + 31) + nbits(2, t + 1, t + 31)
        + nbits(3, t + 1, t + 31) !== 0) begin
      fails++;
      $display("FAIL short_others: got extra pulses expected none");
    end
    tests++;
    if (obs[t + 15][4] !== 1'b1 || obs[t + 16][4] !== 1'b0) begin
      fails++;
      $display("FAIL short_busy: got %b%b expected 10",
               obs[t + 15][4], obs[t + 16][4]);
    end
  endtask

  task automatic test_long();
    int t = t_now;
    step(1'b1, 1'b0);
    idle(29);
    step(1'b1, 1'b1);
    idle(10);
    tests++;
    if (nbits(1, t + 1, t + 40) !== 1 || obs[t + 21][1] !== 1'b1) begin
      fails++;
      $display("FAIL long_pulse: got n=%0d at21=%b expected 1 at T+21",
               nbits(1, t + 1, t + 40), obs[t + 21][1]);
    end
    tests++;
    if (obs[t + 30][4] !== 1'b1 || obs[t + 31][4] !== 1'b0) begin
      fails++;
      $display("FAIL long_busy: got %b%b expected 10",
               obs[t + 30][4], obs[t + 31][4]);
    end
    tests++;
    if (nbits(3, t + 1, t + 40) !== (REP ? 1 : 0)
        || nbits(0, t + 1, t + 40) + nbits(2, t + 1, t + 40) !== 0) begin
      fails++;
      $display("FAIL long_others: got rep=%0d expected %0d, no short/dbl",
               nbits(3, t + 1, t + 40), REP ? 1 : 0);
    end
  endtask

  task automatic test_double();
    int t = t_now;
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1);
    idle(4);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1);
    idle(25);
    tests++;
    if (nbits(2, t + 1, t + 37) !== 1 || obs[t + 13][2] !== 1'b1) begin
      fails++;
      $display("FAIL double_pulse: got n=%0d at13=%b expected 1 at T+13",
               nbits(2, t + 1, t + 37), obs[t + 13][2]);
    end
    tests++;
    if (nbits(0, t + 1, t + 37) !== 0 || obs[t + 13][4] !== 1'b0) begin
      fails++;
      $display("FAIL double_short: got short=%0d busy=%b expected 0 0",
               nbits(0, t + 1, t + 37), obs[t + 13][4]);
    end
  endtask

  task automatic test_repeat();
    int t = t_now;
    int want;
    step(1'b1, 1'b0);
    idle(44);
    step(1'b1, 1'b1);
    idle(10);
    tests++;
    if (obs[t + 21][1] !== 1'b1 || nbits(1, t + 1, t + 55) !== 1) begin
      fails++;
      $display("FAIL repeat_long: got at21=%b expected 1", obs[t + 21][1]);
    end
    want = REP ? 4 : 0;
    tests++;
    if (nbits(3, t + 1, t + 55) !== want) begin
      fails++;
      $display("FAIL repeat_count: got %0d expected %0d",
               nbits(3, t + 1, t + 55), want);
    end
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (obs[t + 21 + RT * k][3] !== REP) begin
        fails++;
        $display("FAIL repeat_pos%0d: got %b expected %b",
                 k, obs[t + 21 + RT * k][3], REP);
      end
    end
  endtask

  task automatic test_wait2_edge();
    int r;
    step(1'b1, 1'b0);
    idle(5);
    r = t_now;
    step(1'b1, 1'b1);
    idle(9);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1);
    idle(20);
    tests++;
    if (nbits(0, r + 1, r + 35) !== 0) begin
      fails++;
      $display("FAIL wait2_edge_short: got %0d expected 0",
               nbits(0, r + 1, r + 35));
    end
    tests++;
    if (obs[r + 15][2] !== 1'b1 || nbits(2, r + 1, r + 35) !== 1) begin
      fails++;
      $display("FAIL wait2_edge_double: got at15=%b expected 1",
               obs[r + 15][2]);
    end
  endtask

  task automatic test_redundant();
    int p;
    step(1'b1, 1'b1);
    idle(2);
    tests++;
    if (obs[t_now][4] !== 1'b0) begin
      fails++;
      $display("FAIL redundant_idle: got busy %b expected 0", obs[t_now][4]);
    end
    p = t_now;
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1);
    idle(2);
    step(1'b1, 1'b1);
    idle(20);
    tests++;
    if (obs[p + 17][0] !== 1'b1 || nbits(0, p + 1, p + 30) !== 1
        || nbits(2, p + 1, p + 30) !== 0) begin
      fails++;
      $display("FAIL redundant_short: got at17=%b n=%0d expected 1 1",
               obs[p + 17][0], nbits(0, p + 1, p + 30));
    end
  endtask

  task automatic test_reset_mid();
    int t = t_now;
    logic [4:0] v;
    step(1'b1, 1'b0);
    idle(9);
    rst = 1'b1;
    #1;
    v = outs();
    tests++;
    if (v !== 5'b0) begin
      fails++;
      $display("FAIL reset_async: got %b expected 00000", v);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b0;
    idle(3);
    step(1'b1, 1'b1);
    idle(40);
    tests++;
    if (nbits(0, t + 1, t_now) + nbits(1, t + 1, t_now)
        + nbits(2, t + 1, t_now) + nbits(3, t + 1, t_now) !== 0) begin
      fails++;
      $display("FAIL reset_mid_events: got pulses expected none");
    end
    tests++;
    if (nbits(4, t + 12, t_now) !== 0) begin
      fails++;
      $display("FAIL reset_mid_busy: got %0d busy cycles expected 0",
               nbits(4, t + 12, t_now));
    end
  endtask

  task automatic mark(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) expv[c][4] = 1'b1;
  endtask

  task automatic hold(input int a, input int r);
    expv[a + LT + 1][1] = 1'b1;
    if (REP)
      for (int k = 1; a + LT + 1 + RT * k <= r; k++)
        expv[a + LT + 1 + RT * k][3] = 1'b1;
  endtask

  // Event timing from the gaps between real press/release edges.
  task automatic model(input int ed[$]);
    int i = 0;
    int n = ed.size();
    int p, r, q, s;
    while (i < n) begin
      p = ed[i];
      r = ed[i + 1];
      if (r > p + LT) begin
        hold(p, r);
        mark(p + 1, r);
        i += 2;
      end else if (i + 2 >= n || ed[i + 2] > r + DT) begin
        expv[r + DT + 1][0] = 1'b1;
        mark(p + 1, r + DT);
        i += 2;
      end else begin
        q = ed[i + 2];
        s = ed[i + 3];
        if (s > q + LT) hold(q, s);
        else expv[s + 1][2] = 1'b1;
        mark(p + 1, s);
        i += 4;
      end
    end
  endtask

  task automatic test_random();
    int ed[$];
    int start = t_now;
    int t = start + 2;
    int t_end, idx, nprint;
    for (int k = 0; k < 40; k++) begin
      ed.push_back(t);
      case ($urandom_range(0, 3))
        0: t += $urandom_range(1, 8);
        1: t += $urandom_range(19, 21);
        2: t += $urandom_range(22, 40);
        default: t += $urandom_range(9, 18);
      endcase
      ed.push_back(t);
      case ($urandom_range(0, 3))
        0: t += $urandom_range(1, 6);
        1: t += $urandom_range(9, 12);
        2: t += $urandom_range(13, 25);
        default: t += $urandom_range(7, 8);
      endcase
    end
    t_end = t + 60;
    for (int c = start; c <= t_end + 1; c++) expv[c] = 5'b0;
    model(ed);
    idx = 0;
    for (int c = start; c < t_end; c++) begin
      if (idx < ed.size() && ed[idx] == c) begin
        step(1'b1, idx[0]);
        idx++;
      end else begin
        step(1'b0, 1'b1);
      end
    end
    nprint = 0;
    for (int c = start + 1; c <= t_end; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin
        fails++;
        if (nprint < 10)
          $display("FAIL random_cycle%0d: got %b expected %b",
                   c - start, obs[c], expv[c]);
        nprint++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_flag  = 1'b0;
    key_state = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_repeat();
    test_wait2_edge();
    test_redundant();
    test_reset_mid();
    test_random();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
